// File: rtl/hazard_pkg.sv
// hazard_pkg
// Shared definitions for the pipelined ARM hazard/forwarding unit.
// Contents:
//   FWD_RF / FWD_W / FWD_M : encodings of the per-source Execute forward select
//   PC_REG_DEFAULT         : register index that is never forwarded (r15)
package hazard_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam int PC_REG_DEFAULT = 15;

endpackage : hazard_pkg

// File: rtl/hazard_unit_p_sat_counter.sv
// sat_counter
// Saturating up-counter used for the hazard unit performance counters.
// Ports:
//   clk   in  1      : clock
//   reset in  1      : asynchronous active-low reset, clears the count
//   inc   in  1      : count this cycle
//   clr   in  1      : synchronous clear, wins over inc
//   count out CNT_W  : current count, sticks at all-ones
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // Clear has priority; once the count reaches all-ones it stays there.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {CNT_W{1'b1}})) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule : sat_counter

// File: rtl/hazard_unit_p.sv
// hazard_unit_p
// Parametrised hazard detection and forwarding unit for the pipelined ARM core.
// Ports:
//   clk, reset (async active-low)
//   SrcRegD/SrcValidD       : Decode source indices and used flags (NUM_SRC each)
//   SrcRegE/SrcValidE       : Execute source indices and used flags
//   DstRegE/M/W, RegWriteE/M/W : destination index and write enable per stage
//   MemtoRegE               : Execute instruction is a load
//   PCWrD                   : Decode instruction writes the PC
//   BranchTakenE            : branch resolved taken in Execute
//   PCSrcW                  : PC written in Writeback
//   MemBusyM                : data memory not ready, freezes F..M
//   CntClr                  : synchronous clear of both performance counters
//   ForwardE                : per-source forward select (2 bits each)
//   StallF/D/E/M, FlushD/E/W: pipeline register hold / bubble controls
//   PCWrPendingF            : a PC write is in flight
//   StallCnt, FlushCnt      : saturating performance counters
module hazard_unit_p
    import hazard_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int REG_W   = 4,
    parameter int PC_REG  = PC_REG_DEFAULT,
    parameter int CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_SRC*REG_W-1:0] SrcRegD,
    input  logic [NUM_SRC-1:0]       SrcValidD,
    input  logic [NUM_SRC*REG_W-1:0] SrcRegE,
    input  logic [NUM_SRC-1:0]       SrcValidE,
    input  logic [REG_W-1:0]         DstRegE,
    input  logic [REG_W-1:0]         DstRegM,
    input  logic [REG_W-1:0]         DstRegW,
    input  logic                     RegWriteE,
    input  logic                     RegWriteM,
    input  logic                     RegWriteW,
    input  logic                     MemtoRegE,
    input  logic                     PCWrD,
    input  logic                     BranchTakenE,
    input  logic                     PCSrcW,
    input  logic                     MemBusyM,
    input  logic                     CntClr,
    output logic [NUM_SRC*2-1:0]     ForwardE,
    output logic                     StallF,
    output logic                     StallD,
    output logic                     StallE,
    output logic                     StallM,
    output logic                     FlushD,
    output logic                     FlushE,
    output logic                     FlushW,
    output logic                     PCWrPendingF,
    output logic [CNT_W-1:0]         StallCnt,
    output logic [CNT_W-1:0]         FlushCnt
);

    localparam logic [REG_W-1:0] PC_IDX = REG_W'(PC_REG);

    logic ld_match;
    logic ld_stall;
    logic pcwr_e;
    logic pcwr_m;

    // Forwarding: the M-stage ALU result is newer than the W result, so it is
    // checked first. The PC is read from its own path and is never forwarded.
    always_comb begin
        ForwardE = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SrcValidE[i] && (SrcRegE[i*REG_W +: REG_W] != PC_IDX)) begin
                if (RegWriteM && (DstRegM == SrcRegE[i*REG_W +: REG_W])) begin
                    ForwardE[i*2 +: 2] = FWD_M;
                end else if (RegWriteW && (DstRegW == SrcRegE[i*REG_W +: REG_W])) begin
                    ForwardE[i*2 +: 2] = FWD_W;
                end
            end
        end
    end

    // Load-use: any used Decode source matching the load destination in E.
    always_comb begin
        ld_match = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (SrcValidD[i] && (SrcRegD[i*REG_W +: REG_W] == DstRegE)) begin
                ld_match = 1'b1;
            end
        end
    end

    assign ld_stall     = MemtoRegE & RegWriteE & ld_match;
    assign PCWrPendingF = PCWrD | pcwr_e | pcwr_m;

    // A memory wait freezes F..M and drains W; squashes are deferred until the
    // held instructions can move again, so a held taken branch flushes later.
    assign StallF = MemBusyM | ld_stall | PCWrPendingF;
    assign StallD = MemBusyM | ld_stall;
    assign StallE = MemBusyM;
    assign StallM = MemBusyM;
    assign FlushW = MemBusyM;
    assign FlushD = ~MemBusyM & (PCWrPendingF | PCSrcW | BranchTakenE);
    assign FlushE = ~MemBusyM & (ld_stall | BranchTakenE);

    // PC-write tracker follows the PC-writing instruction through E and M.
    // A flushed E slot carries no PC write; the tracker freezes with the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcwr_e <= 1'b0;
            pcwr_m <= 1'b0;
        end else if (!MemBusyM) begin
            pcwr_e <= PCWrD & ~FlushE;
            pcwr_m <= pcwr_e;
        end
    end

    // StallD already includes the memory-wait term.
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .clr   (CntClr),
        .count (StallCnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (BranchTakenE & ~MemBusyM),
        .clr   (CntClr),
        .count (FlushCnt)
    );

endmodule : hazard_unit_p

// File: tb/tb_hazard_unit_p.sv
// tb_hazard_unit_p
// Self-checking bench for hazard_unit_p (NUM_SRC=3, REG_W=4, CNT_W=4).
// A behavioural model derives every output from the hazard rules each cycle;
// directed sequences add hand-computed literal expectations.
module tb_hazard_unit_p;

    localparam int NS     = 3;
    localparam int RW     = 4;
    localparam int CW     = 4;
    localparam int CNTMAX = 15;

    logic            clk;
    logic            reset;
    logic [NS*RW-1:0] SrcRegD, SrcRegE;
    logic [NS-1:0]   SrcValidD, SrcValidE;
    logic [RW-1:0]   DstRegE, DstRegM, DstRegW;
    logic            RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
    logic            PCWrD, BranchTakenE, PCSrcW, MemBusyM, CntClr;
    logic [NS*2-1:0] ForwardE;
    logic            StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic            PCWrPendingF;
    logic [CW-1:0]   StallCnt, FlushCnt;

    int assertions = 0;
    int failures   = 0;

    // Model state: bit0 = PC writer in E, bit1 = PC writer in M.
    int pcInFlight = 0;
    int stallCntM  = 0;
    int flushCntM  = 0;

    hazard_unit_p #(.NUM_SRC(NS), .REG_W(RW), .PC_REG(15), .CNT_W(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .SrcRegD      (SrcRegD),
        .SrcValidD    (SrcValidD),
        .SrcRegE      (SrcRegE),
        .SrcValidE    (SrcValidE),
        .DstRegE      (DstRegE),
        .DstRegM      (DstRegM),
        .DstRegW      (DstRegW),
        .RegWriteE    (RegWriteE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .MemtoRegE    (MemtoRegE),
        .PCWrD        (PCWrD),
        .BranchTakenE (BranchTakenE),
        .PCSrcW       (PCSrcW),
        .MemBusyM     (MemBusyM),
        .CntClr       (CntClr),
        .ForwardE     (ForwardE),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .PCWrPendingF (PCWrPendingF),
        .StallCnt     (StallCnt),
        .FlushCnt     (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level rule evaluations from the current inputs and model state.
    function automatic bit modelLdStall();
        bit hit = 0;
        for (int i = 0; i < NS; i++)
            if (SrcValidD[i] && (SrcRegD[i*RW +: RW] == DstRegE)) hit = 1;
        return MemtoRegE && RegWriteE && hit;
    endfunction

    function automatic bit modelPending();
        return PCWrD || (pcInFlight != 0);
    endfunction

    function automatic int modelFwd(input int i);
        int src = int'(SrcRegE[i*RW +: RW]);
        if (!SrcValidE[i] || src == 15) return 0;
        if (RegWriteM && int'(DstRegM) == src) return 2;
        if (RegWriteW && int'(DstRegW) == src) return 1;
        return 0;
    endfunction

    // Model advance at each clock edge; asynchronous clear on reset.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            pcInFlight <= 0;
            stallCntM  <= 0;
            flushCntM  <= 0;
        end else begin
            if (CntClr) begin
                stallCntM <= 0;
                flushCntM <= 0;
            end else begin
                if ((MemBusyM || modelLdStall()) && stallCntM < CNTMAX)
                    stallCntM <= stallCntM + 1;
                if (BranchTakenE && !MemBusyM && flushCntM < CNTMAX)
                    flushCntM <= flushCntM + 1;
            end
            if (!MemBusyM)
                pcInFlight <= ((pcInFlight << 1) |
                               int'(PCWrD && !(modelLdStall() || BranchTakenE))) & 3;
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin : compareProc
        bit ld, pend, busy;
        ld   = modelLdStall();
        pend = modelPending();
        busy = MemBusyM;
        for (int i = 0; i < NS; i++)
            checkOutput($sformatf("mdl ForwardE[%0d]", i), int'(ForwardE[i*2 +: 2]), modelFwd(i));
        checkOutput("mdl StallF", int'(StallF), int'(busy || ld || pend));
        checkOutput("mdl StallD", int'(StallD), int'(busy || ld));
        checkOutput("mdl StallE", int'(StallE), int'(busy));
        checkOutput("mdl StallM", int'(StallM), int'(busy));
        checkOutput("mdl FlushW", int'(FlushW), int'(busy));
        checkOutput("mdl FlushD", int'(FlushD), int'(!busy && (pend || PCSrcW || BranchTakenE)));
        checkOutput("mdl FlushE", int'(FlushE), int'(!busy && (ld || BranchTakenE)));
        checkOutput("mdl PCWrPendingF", int'(PCWrPendingF), int'(pend));
        checkOutput("mdl StallCnt", int'(StallCnt), stallCntM);
        checkOutput("mdl FlushCnt", int'(FlushCnt), flushCntM);
    end

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        SrcRegD = '0; SrcValidD = '0; SrcRegE = '0; SrcValidE = '0;
        DstRegE = '0; DstRegM = '0; DstRegW = '0;
        RegWriteE = 0; RegWriteM = 0; RegWriteW = 0; MemtoRegE = 0;
        PCWrD = 0; BranchTakenE = 0; PCSrcW = 0; MemBusyM = 0; CntClr = 0;
    endtask

    initial begin
        reset = 1'b0;
        clearInputs();
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("in reset StallF", int'(StallF), 0);
        checkOutput("in reset StallCnt", int'(StallCnt), 0);
        applyStimulus();
        reset = 1'b1;

        // Idle out of reset: every output zero.
        @(negedge clk);
        checkOutput("idle ForwardE", int'(ForwardE), 0);
        checkOutput("idle FlushD", int'(FlushD), 0);
        checkOutput("idle PCWrPendingF", int'(PCWrPendingF), 0);

        // M-stage forward beats W.
        applyStimulus();
        SrcRegE = {4'd0, 4'd0, 4'd3}; SrcValidE = 3'b001;
        RegWriteM = 1; DstRegM = 3; RegWriteW = 1; DstRegW = 3;
        @(negedge clk);
        checkOutput("fwd M over W", int'(ForwardE[1:0]), 2);
        applyStimulus();
        RegWriteM = 0;
        @(negedge clk);
        checkOutput("fwd W only", int'(ForwardE[1:0]), 1);

        // PC never forwarded; other source picks up W.
        applyStimulus();
        SrcRegE = {4'd5, 4'd15, 4'd0}; SrcValidE = 3'b110;
        RegWriteM = 1; DstRegM = 15; RegWriteW = 1; DstRegW = 5;
        @(negedge clk);
        checkOutput("fwd PC blocked", int'(ForwardE[3:2]), 0);
        checkOutput("fwd src2 from W", int'(ForwardE[5:4]), 1);

        // Load-use stall for one cycle, then bubble in E clears it.
        applyStimulus();
        clearInputs();
        MemtoRegE = 1; RegWriteE = 1; DstRegE = 2;
        SrcRegD = {4'd2, 4'd0, 4'd0}; SrcValidD = 3'b100;
        @(negedge clk);
        checkOutput("ldstall StallF", int'(StallF), 1);
        checkOutput("ldstall StallD", int'(StallD), 1);
        checkOutput("ldstall FlushE", int'(FlushE), 1);
        applyStimulus();
        MemtoRegE = 0; RegWriteE = 0;
        @(negedge clk);
        checkOutput("ldstall over StallD", int'(StallD), 0);
        checkOutput("ldstall over FlushE", int'(FlushE), 0);
        applyStimulus();
        MemtoRegE = 1; RegWriteE = 1; SrcValidD = 3'b000;
        @(negedge clk);
        checkOutput("ld unused src StallD", int'(StallD), 0);

        // PC write: StallF 3 cycles, FlushD 4 cycles (through PCSrcW).
        applyStimulus();
        clearInputs();
        for (int k = 0; k < 6; k++) begin
            PCWrD  = (k == 0);
            PCSrcW = (k == 3);
            @(negedge clk);
            checkOutput($sformatf("pcwr StallF c%0d", k), int'(StallF), int'(k < 3));
            checkOutput($sformatf("pcwr FlushD c%0d", k), int'(FlushD), int'(k < 4));
            checkOutput($sformatf("pcwr pending c%0d", k), int'(PCWrPendingF), int'(k < 3));
            applyStimulus();
        end

        // Memory wait over a taken branch, flush deferred to release.
        clearInputs();
        CntClr = 1;
        applyStimulus();
        CntClr = 0;
        BranchTakenE = 1; MemBusyM = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checkOutput("busy StallE", int'(StallE), 1);
            checkOutput("busy StallM", int'(StallM), 1);
            checkOutput("busy FlushW", int'(FlushW), 1);
            checkOutput("busy FlushD", int'(FlushD), 0);
            checkOutput("busy FlushE", int'(FlushE), 0);
            applyStimulus();
        end
        MemBusyM = 0;
        @(negedge clk);
        checkOutput("release FlushD", int'(FlushD), 1);
        checkOutput("release FlushE", int'(FlushE), 1);
        checkOutput("release FlushCnt", int'(FlushCnt), 0);
        applyStimulus();
        BranchTakenE = 0;
        @(negedge clk);
        checkOutput("after release FlushCnt", int'(FlushCnt), 1);
        checkOutput("after release StallCnt", int'(StallCnt), 2);

        // Saturation after 20 stall cycles, then clear.
        applyStimulus();
        MemBusyM = 1;
        repeat (20) applyStimulus();
        MemBusyM = 0;
        @(negedge clk);
        checkOutput("sat StallCnt", int'(StallCnt), 15);
        applyStimulus();
        CntClr = 1;
        applyStimulus();
        CntClr = 0;
        @(negedge clk);
        checkOutput("clr StallCnt", int'(StallCnt), 0);
        checkOutput("clr FlushCnt", int'(FlushCnt), 0);

        // Reset mid-stall with a PC write held in E.
        applyStimulus();
        PCWrD = 1;
        applyStimulus();
        PCWrD = 0; MemBusyM = 1;
        applyStimulus();
        applyStimulus();
        @(negedge clk);
        checkOutput("held pending", int'(PCWrPendingF), 1);
        checkOutput("held StallCnt", int'(StallCnt), 2);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("async rst pending", int'(PCWrPendingF), 0);
        checkOutput("async rst StallCnt", int'(StallCnt), 0);
        checkOutput("async rst StallF", int'(StallF), 1);
        applyStimulus();
        clearInputs();
        applyStimulus();
        reset = 1'b1;
        repeat (3) applyStimulus();
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule : tb_hazard_unit_p

// File: doc/hazard_unit_p.md
# hazard_unit_p

Parametrised hazard and forwarding unit for the pipelined ARM core. It replaces the fixed two-operand hazard unit with one that handles:
- `NUM_SRC` Execute-stage source operands;
- an internal PC-write-pending tracker, instead of taking `PCWrPendingF` from the controller;
- a data-memory wait (`MemBusyM`) that freezes F..M;
- saturating stall and flush performance counters.

It sits beside `datapath` and `controller` in `arm`.

## Interface
Parameters:
- `NUM_SRC`, 3: source operands per instruction (Rn, Rm, Rs).
- `REG_W`, 4: register index width.
- `PC_REG`, 15: register index that is never forwarded.
- `CNT_W`, 16: performance counter width.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low reset.
- `SrcRegD` in NUM_SRC×REG_W: Decode source indices.
- `SrcValidD` in NUM_SRC: Decode source-used flags.
- `SrcRegE` in NUM_SRC×REG_W: Execute source indices.
- `SrcValidE` in NUM_SRC: Execute source-used flags.
- `DstRegE`, `DstRegM`, `DstRegW` in REG_W: destination index in each stage.
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: register write enable in each stage.
- `MemtoRegE` in 1: the instruction in Execute is a load.
- `PCWrD` in 1: the instruction in Decode writes the PC.
- `BranchTakenE` in 1: branch resolved taken in Execute.
- `PCSrcW` in 1: the PC is written in Writeback.
- `MemBusyM` in 1: data memory is not ready.
- `CntClr` in 1: synchronous counter clear.
- `ForwardE` out NUM_SRC×2: per-source select; 00 = regfile, 01 = W result, 10 = M ALU result.
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the F, D, E, M pipeline registers.
- `FlushD`, `FlushE`, `FlushW` out 1: insert a bubble into the D, E, W registers.
- `PCWrPendingF` out 1: a PC write is in flight.
- `StallCnt`, `FlushCnt` out CNT_W: performance counters.

## Operation

**Forwarding (per source i)**
- Select 10 if `SrcValidE[i]`, `RegWriteM` and `DstRegM==SrcRegE[i]` all hold, and `SrcRegE[i]!=PC_REG`.
- Otherwise select 01 under the same conditions using `RegWriteW`/`DstRegW`.
- Otherwise select 00.
- M has priority over W.

**Load-use hazard**
- `LdStall` = `MemtoRegE & RegWriteE` and, for any i, `SrcValidD[i] & (SrcRegD[i]==DstRegE)`.

**PC-write tracker**
- Holds two state bits, `pcwrE` and `pcwrM`.
- `PCWrPendingF = PCWrD | pcwrE | pcwrM`.

**Normal mode (`MemBusyM`=0)**
- `StallF = LdStall | PCWrPendingF`.
- `StallD = LdStall`.
- `StallE = StallM = FlushW = 0`.
- `FlushD = PCWrPendingF | PCSrcW | BranchTakenE`.
- `FlushE = LdStall | BranchTakenE`.
- Tracker update: `pcwrE <= PCWrD & ~FlushE`; `pcwrM <= pcwrE`.

**Memory wait (`MemBusyM`=1)**
- `StallF`, `StallD`, `StallE`, `StallM` = 1.
- `FlushW` = 1.
- `FlushD` = `FlushE` = 0. Held instructions are not squashed, including a taken branch held in E.
- The tracker holds its state.
- `PCWrPendingF` is still driven from the held state.

**Counters**
- `StallCnt` increments on cycles with `StallD | MemBusyM`.
- `FlushCnt` increments on cycles with `BranchTakenE & ~MemBusyM`.
- Both saturate at all-ones and do not wrap.
- `CntClr` zeroes both on the next edge and has priority over increment.

## Timing
- All stall, flush and forward outputs are combinational from same-cycle inputs and state. There are no registered outputs other than the counters.
- When `reset` falls (asserted, mid-operation or not), `pcwrE`, `pcwrM`, `StallCnt` and `FlushCnt` clear immediately.
- While in reset, the combinational outputs are evaluated with the cleared state.
- Out of reset with all inputs 0, every output is 0.
- A load-use stall lasts exactly 1 cycle: the bubble in E removes the match.
- A PC write in D keeps `StallF` high until the PC-writing instruction reaches W. `FlushD` then stays high through the `PCSrcW` cycle.
- Simultaneous `BranchTakenE` and `LdStall`: both `FlushE` and `StallD` assert. The branch redirect wins because `FlushD` is also set.
- `MemBusyM` asserted for N cycles extends every in-flight hazard by exactly N cycles.

## Structure
- Shared package `hazard_pkg`:
  - forward-select encodings `FWD_RF=2'b00`, `FWD_W=2'b01`, `FWD_M=2'b10`;
  - `PC_REG` default.
- One natural sub-module, `sat_counter` (CNT_W, inc, clr), instantiated twice.
- The remaining logic (forward compare loop, hazard equations, tracker flops) stays in `hazard_unit_p`.

## Test plan
1. **M-stage forward.** `SrcRegE[0]`=3 valid, `RegWriteM`=1, `DstRegM`=3, and `RegWriteW`=1, `DstRegW`=3 → `ForwardE[0]`=10 (M beats W).
2. **PC never forwarded.** `SrcRegE[1]`=15, `DstRegM`=15, `RegWriteM`=1 → `ForwardE[1]`=00.
3. **Load-use stall.** Load to r2 in E, `SrcRegD[2]`=2 valid → one cycle of `StallF`/`StallD`/`FlushE`=1, then 0 on the next cycle.
4. **PC-write pending.** `PCWrD` pulse, then `PCSrcW` three cycles later → `StallF` high 3 cycles, `FlushD` high 4 cycles, `PCWrPendingF` low afterwards.
5. **Memory wait over a branch.** `MemBusyM` high 2 cycles while `BranchTakenE`=1 → all stalls 1, `FlushW`=1, `FlushD`/`FlushE`=0. The flush happens on the release cycle and `FlushCnt` increments by 1.
6. **Counters and reset.** With `CNT_W`=4, 20 stall cycles → `StallCnt`=15. Then `CntClr` → 0. Asserting `reset` mid-stall clears the tracker and counters immediately.
